// File: rtl/rgb_frame_sequencer.sv
// Frame-level controller for the RGB pixel datapath: counts beats and lines,
// regenerates t_last/start-of-frame and steers each frame to passthrough or convert.
module rgb_frame_sequencer #(
  parameter int DATA_WIDTH = 64,
  parameter int DEST_WIDTH = 1,
  parameter int USER_WIDTH = 1,
  parameter int ID_WIDTH   = 1,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                    aclk,
  input  logic                    areset,
  input  logic                    cfg_start,
  input  logic                    cfg_abort,
  input  logic                    cfg_mode,
  input  logic [CNT_WIDTH-1:0]    cfg_line_beats,
  input  logic [CNT_WIDTH-1:0]    cfg_lines,
  output logic                    busy,
  output logic                    done,
  output logic                    aborted,
  output logic                    err_odd,
  output logic                    err_sync,
  output logic [CNT_WIDTH-1:0]    frame_cnt,
  input  logic                    src_t_valid,
  output logic                    src_t_ready,
  input  logic [DATA_WIDTH-1:0]   src_t_data,
  input  logic [DATA_WIDTH/8-1:0] src_t_keep,
  input  logic [DATA_WIDTH/8-1:0] src_t_strb,
  input  logic                    src_t_last,
  output logic                    m_pass_t_valid,
  input  logic                    m_pass_t_ready,
  output logic [DATA_WIDTH-1:0]   m_pass_t_data,
  output logic [DATA_WIDTH/8-1:0] m_pass_t_keep,
  output logic [DATA_WIDTH/8-1:0] m_pass_t_strb,
  output logic                    m_pass_t_last,
  output logic [DEST_WIDTH-1:0]   m_pass_t_dest,
  output logic [ID_WIDTH-1:0]     m_pass_t_id,
  output logic [USER_WIDTH-1:0]   m_pass_t_user,
  output logic                    m_conv_t_valid,
  input  logic                    m_conv_t_ready,
  output logic [DATA_WIDTH-1:0]   m_conv_t_data,
  output logic [DATA_WIDTH/8-1:0] m_conv_t_keep,
  output logic [DATA_WIDTH/8-1:0] m_conv_t_strb,
  output logic                    m_conv_t_last,
  output logic [DEST_WIDTH-1:0]   m_conv_t_dest,
  output logic [ID_WIDTH-1:0]     m_conv_t_id,
  output logic [USER_WIDTH-1:0]   m_conv_t_user
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                 state_q, state_d;
  logic                   mode_q;
  logic [CNT_WIDTH-1:0]   line_beats_q, lines_q;
  logic [CNT_WIDTH-1:0]   beat_cnt, line_cnt;
  logic                   run, sel_ready, xfer, line_end, last_line, sof, cfg_zero;

  assign cfg_zero  = (cfg_line_beats == '0) || (cfg_lines == '0);
  assign line_end  = (beat_cnt == line_beats_q - CNT_WIDTH'(1));
  assign last_line = (line_cnt == lines_q - CNT_WIDTH'(1));
  assign sof       = (beat_cnt == '0) && (line_cnt == '0);
  // Gating with areset keeps a reset cycle from ever completing a handshake.
  assign run       = (state_q == RUN) && !areset;
  assign sel_ready = mode_q ? m_conv_t_ready : m_pass_t_ready;
  assign xfer      = src_t_valid && src_t_ready;

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);

  always_ff @(posedge aclk) begin
    if (areset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (cfg_start) begin
          if (cfg_zero)                            state_d = DONE;
          else if (cfg_mode && cfg_line_beats[0])  state_d = IDLE;
          else                                     state_d = RUN;
        end
      end
      RUN: begin
        if (cfg_abort)                             state_d = IDLE;
        else if (xfer && line_end && last_line)    state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // The stream path is purely combinational; only the selected master sees the beat.
  always_comb begin
    src_t_ready    = run && sel_ready;
    m_pass_t_valid = run && !mode_q && src_t_valid;
    m_conv_t_valid = run && mode_q && src_t_valid;
    m_pass_t_data  = src_t_data;
    m_conv_t_data  = src_t_data;
    m_pass_t_keep  = src_t_keep;
    m_conv_t_keep  = src_t_keep;
    m_pass_t_strb  = src_t_strb;
    m_conv_t_strb  = src_t_strb;
    m_pass_t_last  = run && !mode_q && line_end;
    m_conv_t_last  = run && mode_q && line_end;
    m_pass_t_dest  = '0;
    m_conv_t_dest  = '0;
    m_pass_t_id    = '0;
    m_conv_t_id    = '0;
    m_pass_t_user  = '0;
    m_conv_t_user  = '0;
    m_pass_t_user[0] = run && !mode_q && sof;
    m_conv_t_user[0] = run && mode_q && sof;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge aclk) begin
    if (areset) begin
      mode_q       <= 1'b0;
      line_beats_q <= '0;
      lines_q      <= '0;
      beat_cnt     <= '0;
      line_cnt     <= '0;
      aborted      <= 1'b0;
      err_odd      <= 1'b0;
      err_sync     <= 1'b0;
      frame_cnt    <= '0;
    end else begin
      aborted <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (cfg_start) begin
            mode_q       <= cfg_mode;
            line_beats_q <= cfg_line_beats;
            lines_q      <= cfg_lines;
            beat_cnt     <= '0;
            line_cnt     <= '0;
            err_odd      <= !cfg_zero && cfg_mode && cfg_line_beats[0];
            err_sync     <= 1'b0;
          end
        end
        RUN: begin
          if (xfer) begin
            if (src_t_last && !line_end) err_sync <= 1'b1;
            if (line_end) begin
              beat_cnt <= '0;
              line_cnt <= last_line ? '0 : line_cnt + CNT_WIDTH'(1);
            end else begin
              beat_cnt <= beat_cnt + CNT_WIDTH'(1);
            end
          end
          if (cfg_abort) begin
            beat_cnt <= '0;
            line_cnt <= '0;
            aborted  <= 1'b1;
          end
        end
        DONE:    frame_cnt <= frame_cnt + CNT_WIDTH'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rgb_frame_sequencer.sv
// Scoreboard bench for rgb_frame_sequencer: expected beats are queued as the source
// presents them and compared against the selected master when it accepts them.
module tb_rgb_frame_sequencer;
  localparam int DW = 64;
  localparam int KW = DW / 8;
  localparam int CW = 16;
  localparam int WW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          areset, cfg_start, cfg_abort, cfg_mode;
  logic [CW-1:0] cfg_line_beats, cfg_lines;
  logic          busy, done, aborted, err_odd, err_sync;
  logic [CW-1:0] frame_cnt;
  logic          src_t_valid, src_t_ready, src_t_last;
  logic [DW-1:0] src_t_data;
  logic [KW-1:0] src_t_keep, src_t_strb;
  logic          m_pass_t_valid, m_pass_t_ready, m_pass_t_last;
  logic [DW-1:0] m_pass_t_data;
  logic [KW-1:0] m_pass_t_keep, m_pass_t_strb;
  logic [0:0]    m_pass_t_dest, m_pass_t_id, m_pass_t_user;
  logic          m_conv_t_valid, m_conv_t_ready, m_conv_t_last;
  logic [DW-1:0] m_conv_t_data;
  logic [KW-1:0] m_conv_t_keep, m_conv_t_strb;
  logic [0:0]    m_conv_t_dest, m_conv_t_id, m_conv_t_user;

  // Narrow-counter instance so the frame counter wrap is reachable in a short run.
  logic          w_start;
  logic [WW-1:0] w_line_beats, w_lines, w_frame_cnt;
  logic          w_busy, w_done, w_aborted, w_err_odd, w_err_sync, w_src_t_ready;
  logic          w_pass_t_valid, w_pass_t_last, w_conv_t_valid, w_conv_t_last;
  logic [DW-1:0] w_pass_t_data, w_conv_t_data;
  logic [KW-1:0] w_pass_t_keep, w_pass_t_strb, w_conv_t_keep, w_conv_t_strb;
  logic [0:0]    w_pass_t_dest, w_pass_t_id, w_pass_t_user;
  logic [0:0]    w_conv_t_dest, w_conv_t_id, w_conv_t_user;

  rgb_frame_sequencer #(.CNT_WIDTH(CW)) dut (
    .aclk(clk), .areset(areset), .cfg_start(cfg_start), .cfg_abort(cfg_abort),
    .cfg_mode(cfg_mode), .cfg_line_beats(cfg_line_beats), .cfg_lines(cfg_lines),
    .busy(busy), .done(done), .aborted(aborted), .err_odd(err_odd), .err_sync(err_sync),
    .frame_cnt(frame_cnt),
    .src_t_valid(src_t_valid), .src_t_ready(src_t_ready), .src_t_data(src_t_data),
    .src_t_keep(src_t_keep), .src_t_strb(src_t_strb), .src_t_last(src_t_last),
    .m_pass_t_valid(m_pass_t_valid), .m_pass_t_ready(m_pass_t_ready),
    .m_pass_t_data(m_pass_t_data), .m_pass_t_keep(m_pass_t_keep),
    .m_pass_t_strb(m_pass_t_strb), .m_pass_t_last(m_pass_t_last),
    .m_pass_t_dest(m_pass_t_dest), .m_pass_t_id(m_pass_t_id), .m_pass_t_user(m_pass_t_user),
    .m_conv_t_valid(m_conv_t_valid), .m_conv_t_ready(m_conv_t_ready),
    .m_conv_t_data(m_conv_t_data), .m_conv_t_keep(m_conv_t_keep),
    .m_conv_t_strb(m_conv_t_strb), .m_conv_t_last(m_conv_t_last),
    .m_conv_t_dest(m_conv_t_dest), .m_conv_t_id(m_conv_t_id), .m_conv_t_user(m_conv_t_user)
  );

  rgb_frame_sequencer #(.CNT_WIDTH(WW)) dut_w (
    .aclk(clk), .areset(areset), .cfg_start(w_start), .cfg_abort(1'b0),
    .cfg_mode(1'b0), .cfg_line_beats(w_line_beats), .cfg_lines(w_lines),
    .busy(w_busy), .done(w_done), .aborted(w_aborted), .err_odd(w_err_odd),
    .err_sync(w_err_sync), .frame_cnt(w_frame_cnt),
    .src_t_valid(1'b0), .src_t_ready(w_src_t_ready), .src_t_data('0),
    .src_t_keep('0), .src_t_strb('0), .src_t_last(1'b0),
    .m_pass_t_valid(w_pass_t_valid), .m_pass_t_ready(1'b1),
    .m_pass_t_data(w_pass_t_data), .m_pass_t_keep(w_pass_t_keep),
    .m_pass_t_strb(w_pass_t_strb), .m_pass_t_last(w_pass_t_last),
    .m_pass_t_dest(w_pass_t_dest), .m_pass_t_id(w_pass_t_id), .m_pass_t_user(w_pass_t_user),
    .m_conv_t_valid(w_conv_t_valid), .m_conv_t_ready(1'b1),
    .m_conv_t_data(w_conv_t_data), .m_conv_t_keep(w_conv_t_keep),
    .m_conv_t_strb(w_conv_t_strb), .m_conv_t_last(w_conv_t_last),
    .m_conv_t_dest(w_conv_t_dest), .m_conv_t_id(w_conv_t_id), .m_conv_t_user(w_conv_t_user)
  );

  typedef struct packed {
    logic [DW-1:0] data;
    logic [KW-1:0] keep;
    logic [KW-1:0] strb;
    logic          last;
    logic          sof;
  } beat_t;

  beat_t exp_q[$];
  int    checks = 0;
  int    errors = 0;
  int    exp_frames = 0;

  // Entered and left at posedge+1; the start is sampled on the next edge.
  task automatic do_start(input bit mode, input int lb, input int ln);
    cfg_mode       = mode;
    cfg_line_beats = CW'(lb);
    cfg_lines      = CW'(ln);
    cfg_start      = 1'b1;
    @(posedge clk); #1;
    cfg_start      = 1'b0;
  endtask

  // Presents beats until stop_after (or the whole frame) have been accepted.
  task automatic stream_frame(input string nm, input bit mode, input int lb, input int ln,
                              input bit [3:0] rdy_pat, input int bad_beat, input int stop_after);
    int    limit = (stop_after >= 0) ? stop_after : lb * ln;
    int    beat = 0;
    int    cyc = 0;
    bit    have = 1'b0;
    bit    rdy;
    beat_t e;
    logic [2*KW+DW+6:0] obs, expv;
    while (beat < limit && cyc < 200) begin
      if (!have) begin
        src_t_data  = {$urandom(), $urandom()};
        src_t_keep  = KW'($urandom());
        src_t_strb  = KW'($urandom());
        src_t_last  = (beat == bad_beat);
        src_t_valid = 1'b1;
        e.data = src_t_data;
        e.keep = src_t_keep;
        e.strb = src_t_strb;
        e.last = ((beat % lb) == lb - 1);
        e.sof  = (beat == 0);
        exp_q.push_back(e);
        have = 1'b1;
      end
      rdy = rdy_pat[cyc % 4];
      m_pass_t_ready = mode ? 1'b1 : rdy;
      m_conv_t_ready = mode ? rdy : 1'b1;
      @(negedge clk);
      if (mode)
        obs = {m_conv_t_valid, m_pass_t_valid, m_conv_t_last, m_conv_t_user, src_t_ready,
               m_conv_t_dest, m_conv_t_id, m_conv_t_keep, m_conv_t_strb, m_conv_t_data};
      else
        obs = {m_pass_t_valid, m_conv_t_valid, m_pass_t_last, m_pass_t_user, src_t_ready,
               m_pass_t_dest, m_pass_t_id, m_pass_t_keep, m_pass_t_strb, m_pass_t_data};
      e = exp_q[0];
      expv = {1'b1, 1'b0, e.last, e.sof, rdy, 1'b0, 1'b0, e.keep, e.strb, e.data};
      checks++;
      if (obs !== expv) begin
        errors++;
        $display("FAIL %s beat %0d: got %h expected %h", nm, beat, obs, expv);
      end
      if (rdy) begin
        void'(exp_q.pop_front());
        beat++;
        have = 1'b0;
      end
      @(posedge clk); #1;
      cyc++;
    end
    checks++;
    if (cyc >= 200) begin
      errors++;
      $display("FAIL %s timeout: accepted %0d beats, required %0d", nm, beat, limit);
    end
    src_t_valid = 1'b0;
    src_t_last  = 1'b0;
  endtask

  // Expects the DONE cycle now, then the incremented frame count in the following IDLE cycle.
  task automatic finish_frame(input string nm);
    @(negedge clk);
    checks++;
    if ({done, busy, src_t_ready, m_pass_t_valid, m_conv_t_valid} !== 5'b10000) begin
      errors++;
      $display("FAIL %s done cycle: done/busy/ready/pv/cv got %b expected 10000", nm,
               {done, busy, src_t_ready, m_pass_t_valid, m_conv_t_valid});
    end
    @(posedge clk); #1;
    exp_frames++;
    checks++;
    if ({done, frame_cnt} !== {1'b0, CW'(exp_frames)}) begin
      errors++;
      $display("FAIL %s after done: done %b frame_cnt %0d expected 0 / %0d", nm, done,
               frame_cnt, exp_frames);
    end
  endtask

  task automatic check_idle_outputs(input string nm);
    logic [7+CW-1:0] obs;
    obs = {busy, done, aborted, err_odd, err_sync, src_t_ready,
           m_pass_t_valid | m_conv_t_valid, frame_cnt};
    checks++;
    if (obs !== '0) begin
      errors++;
      $display("FAIL %s: status got %h expected 0", nm, obs);
    end
  endtask

  task automatic test_reset();
    areset = 1'b1; cfg_start = 1'b1; src_t_valid = 1'b1;
    m_pass_t_ready = 1'b1; m_conv_t_ready = 1'b1;
    cfg_line_beats = 16'd4; cfg_lines = 16'd1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_idle_outputs("reset_held");
    @(posedge clk); #1;
    areset = 1'b0; cfg_start = 1'b0;
    @(negedge clk);
    check_idle_outputs("reset_released_idle");
    @(posedge clk); #1;
    src_t_valid = 1'b0;
  endtask

  task automatic test_passthrough();
    do_start(1'b0, 4, 2);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL pass_busy: got %b expected 1", busy);
    end
    stream_frame("pass", 1'b0, 4, 2, 4'b1111, -1, -1);
    finish_frame("pass");
  endtask

  task automatic test_convert();
    do_start(1'b1, 2, 3);
    stream_frame("conv", 1'b1, 2, 3, 4'b0101, -1, -1);
    finish_frame("conv");
  endtask

  task automatic test_config_errors();
    src_t_valid = 1'b1;
    src_t_data  = 64'hDEAD_BEEF_0BAD_F00D;
    do_start(1'b1, 3, 2);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if ({busy, err_odd, done, src_t_ready, m_pass_t_valid, m_conv_t_valid} !== 6'b010000) begin
        errors++;
        $display("FAIL odd_cfg cycle %0d: busy/err_odd/done/ready/pv/cv got %b expected 010000",
                 i, {busy, err_odd, done, src_t_ready, m_pass_t_valid, m_conv_t_valid});
      end
      @(posedge clk); #1;
    end
    do_start(1'b0, 0, 5);
    checks++;
    if (err_odd !== 1'b0) begin
      errors++;
      $display("FAIL empty_clears_err_odd: got %b expected 0", err_odd);
    end
    finish_frame("empty");
    src_t_valid = 1'b0;
  endtask

  task automatic test_sync();
    do_start(1'b0, 4, 1);
    stream_frame("sync", 1'b0, 4, 1, 4'b1111, 1, -1);
    checks++;
    if (err_sync !== 1'b1) begin
      errors++;
      $display("FAIL sync_err: got %b expected 1", err_sync);
    end
    finish_frame("sync");
  endtask

  task automatic test_back_to_back();
    do_start(1'b0, 2, 1);
    checks++;
    if (err_sync !== 1'b0) begin
      errors++;
      $display("FAIL b2b_err_sync_cleared: got %b expected 0", err_sync);
    end
    stream_frame("b2b_a", 1'b0, 2, 1, 4'b1111, -1, -1);
    finish_frame("b2b_a");
    do_start(1'b1, 2, 1);
    stream_frame("b2b_b", 1'b1, 2, 1, 4'b1111, -1, -1);
    finish_frame("b2b_b");
  endtask

  task automatic test_abort();
    do_start(1'b0, 4, 4);
    stream_frame("abort_pre", 1'b0, 4, 4, 4'b1111, -1, 3);
    cfg_abort = 1'b1;
    @(posedge clk); #1;
    cfg_abort = 1'b0;
    @(negedge clk);
    checks++;
    if ({aborted, busy, done, frame_cnt} !== {3'b100, CW'(exp_frames)}) begin
      errors++;
      $display("FAIL abort_pulse: aborted/busy/done %b frame_cnt %0d expected 100 / %0d",
               {aborted, busy, done}, frame_cnt, exp_frames);
    end
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if ({aborted, busy, done} !== 3'b000) begin
      errors++;
      $display("FAIL abort_one_cycle: got %b expected 000", {aborted, busy, done});
    end
    @(posedge clk); #1;
    do_start(1'b0, 2, 1);
    stream_frame("abort_restart", 1'b0, 2, 1, 4'b1111, -1, -1);
    finish_frame("abort_restart");
  endtask

  task automatic test_reset_mid_frame();
    do_start(1'b0, 4, 2);
    stream_frame("rst_pre", 1'b0, 4, 2, 4'b1111, -1, 2);
    src_t_valid = 1'b1;
    areset = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check_idle_outputs("reset_mid_frame");
    @(posedge clk); #1;
    areset = 1'b0;
    src_t_valid = 1'b0;
    exp_frames = 0;
    exp_q.delete();
  endtask

  task automatic test_wrap();
    w_line_beats = '0;
    w_lines = '0;
    for (int i = 0; i < (1 << WW); i++) begin
      w_start = 1'b1;
      @(posedge clk); #1;
      w_start = 1'b0;
      @(posedge clk); #1;
      if (i == (1 << WW) - 2) begin
        checks++;
        if (w_frame_cnt !== WW'((1 << WW) - 1)) begin
          errors++;
          $display("FAIL wrap_max: got %0d expected %0d", w_frame_cnt, (1 << WW) - 1);
        end
      end
    end
    checks++;
    if (w_frame_cnt !== '0) begin
      errors++;
      $display("FAIL wrap_zero: got %0d expected 0", w_frame_cnt);
    end
  endtask

  initial begin
    areset = 1'b1; cfg_start = 1'b0; cfg_abort = 1'b0; cfg_mode = 1'b0;
    cfg_line_beats = '0; cfg_lines = '0;
    src_t_valid = 1'b0; src_t_last = 1'b0; src_t_data = '0; src_t_keep = '0; src_t_strb = '0;
    m_pass_t_ready = 1'b0; m_conv_t_ready = 1'b0;
    w_start = 1'b0; w_line_beats = '0; w_lines = '0;
    test_reset();
    test_passthrough();
    test_convert();
    test_config_errors();
    test_sync();
    test_back_to_back();
    test_abort();
    test_reset_mid_frame();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
